// File: rtl/zeroriscy_mxbar_pkg.sv
// Shared types and defaults for the zero-riscy N x M crossbar.
// Slave j of the default map occupies bits [j*32 +: 32] of the base/mask vectors.
package zeroriscy_mxbar_pkg;

  localparam int MAX_IDX_W = 8;
  localparam int DEF_N_SLV = 3;
  localparam int DEF_AW    = 32;

  localparam logic [DEF_N_SLV*DEF_AW-1:0] DEF_SLV_BASE =
    {32'h4000_0000, 32'h8010_0000, 32'h8000_0000};
  localparam logic [DEF_N_SLV*DEF_AW-1:0] DEF_SLV_MASK =
    {32'hC000_0000, 32'hFFF0_0000, 32'hFFF0_0000};

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] slv_idx;
    logic                 miss;
  } resp_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/zeroriscy_rr_arb.sv
// Round-robin arbiter over N requesters; the search starts at the pointer,
// which moves one past the winner on every grant.
module zeroriscy_rr_arb
  import zeroriscy_mxbar_pkg::*;
#(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = idx_w(N);

  logic [PW-1:0] ptr_r;
  logic [PW-1:0] win_s;
  logic [PW-1:0] idx_s;
  logic          found_s;

  // First requester at or after the pointer, wrapping past N-1.
  always_comb begin
    win_s   = '0;
    idx_s   = '0;
    found_s = 1'b0;
    gnt     = '0;
    for (int k = 0; k < N; k++) begin
      idx_s = PW'((int'(ptr_r) + k) % N);
      if (!found_s && req[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
    for (int i = 0; i < N; i++) begin
      gnt[i] = found_s && (win_s == PW'(i));
    end
  end

  // Pointer update; held when nothing is granted.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_r <= '0;
    end else if (found_s) begin
      ptr_r <= (win_s == PW'(N - 1)) ? '0 : win_s + PW'(1);
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/zeroriscy_mxbar.sv
// N-master x M-slave crossbar: window decode, per-slave round-robin, decode-error
// responses. Optional stall counters are built when ZERORISCY_MXBAR_STATS_EN is defined.
module zeroriscy_mxbar
  import zeroriscy_mxbar_pkg::*;
#(
  parameter int                    N_MST    = 2,
  parameter int                    N_SLV    = 3,
  parameter int                    AW       = 32,
  parameter int                    DW       = 32,
  parameter logic [N_SLV*AW-1:0]   SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLV*AW-1:0]   SLV_MASK = DEF_SLV_MASK
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef ZERORISCY_MXBAR_STATS_EN
  input  logic                    stat_clr,
  output logic [N_MST*32-1:0]     stat_stall,
`endif
  input  logic [N_MST-1:0]        m_req,
  input  logic [N_MST-1:0]        m_we,
  input  logic [N_MST*DW/8-1:0]   m_be,
  input  logic [N_MST*AW-1:0]     m_addr,
  input  logic [N_MST*DW-1:0]     m_wdata,
  output logic [N_MST-1:0]        m_gnt,
  output logic [N_MST-1:0]        m_rvalid,
  output logic [N_MST*DW-1:0]     m_rdata,
  output logic [N_MST-1:0]        m_err,
  output logic [N_SLV-1:0]        s_req,
  output logic [N_SLV-1:0]        s_we,
  output logic [N_SLV*DW/8-1:0]   s_be,
  output logic [N_SLV*AW-1:0]     s_addr,
  output logic [N_SLV*DW-1:0]     s_wdata,
  input  logic [N_SLV*DW-1:0]     s_rdata,
  input  logic [N_SLV-1:0]        s_err
);

  localparam int BW = DW / 8;

  logic [MAX_IDX_W-1:0] sel_idx_s [N_MST];
  logic [N_MST-1:0]     hit_s;
  logic [N_MST-1:0]     miss_s;
  logic [N_MST-1:0]     slv_req_s [N_SLV];
  logic [N_MST-1:0]     slv_gnt_s [N_SLV];
  resp_t                resp_r    [N_MST];

  // Address decode; the downward scan lets the lowest matching window win.
  always_comb begin
    for (int i = 0; i < N_MST; i++) begin
      sel_idx_s[i] = '0;
      hit_s[i]     = 1'b0;
      for (int j = N_SLV - 1; j >= 0; j--) begin
        if ((m_addr[i*AW +: AW] & SLV_MASK[j*AW +: AW]) == SLV_BASE[j*AW +: AW]) begin
          sel_idx_s[i] = MAX_IDX_W'(j);
          hit_s[i]     = 1'b1;
        end else begin
          sel_idx_s[i] = sel_idx_s[i];
        end
      end
      miss_s[i] = m_req[i] && !reset && !hit_s[i];
    end
  end

  // Per-slave request vectors, masked while reset is high.
  always_comb begin
    for (int j = 0; j < N_SLV; j++) begin
      for (int i = 0; i < N_MST; i++) begin
        slv_req_s[j][i] = m_req[i] && !reset && hit_s[i] &&
                          (sel_idx_s[i] == MAX_IDX_W'(j));
      end
    end
  end

  for (genvar j = 0; j < N_SLV; j++) begin : g_arb
    zeroriscy_rr_arb #(.N(N_MST)) u_arb (
      .clk   (clk),
      .reset (reset),
      .req   (slv_req_s[j]),
      .gnt   (slv_gnt_s[j])
    );
  end

  // Master grants: decode misses are accepted without arbitration.
  always_comb begin
    for (int i = 0; i < N_MST; i++) begin
      m_gnt[i] = miss_s[i];
      for (int j = 0; j < N_SLV; j++) begin
        m_gnt[i] = m_gnt[i] | slv_gnt_s[j][i];
      end
    end
  end

  // Slave-side AND-OR mux from the one-hot winner; all zero when idle.
  always_comb begin
    s_req   = '0;
    s_we    = '0;
    s_be    = '0;
    s_addr  = '0;
    s_wdata = '0;
    for (int j = 0; j < N_SLV; j++) begin
      s_req[j] = |slv_gnt_s[j];
      for (int i = 0; i < N_MST; i++) begin
        s_we[j]              = s_we[j] | (slv_gnt_s[j][i] & m_we[i]);
        s_be[j*BW +: BW]     = s_be[j*BW +: BW] | ({BW{slv_gnt_s[j][i]}} & m_be[i*BW +: BW]);
        s_addr[j*AW +: AW]   = s_addr[j*AW +: AW] | ({AW{slv_gnt_s[j][i]}} & m_addr[i*AW +: AW]);
        s_wdata[j*DW +: DW]  = s_wdata[j*DW +: DW] | ({DW{slv_gnt_s[j][i]}} & m_wdata[i*DW +: DW]);
      end
    end
  end

  // One-cycle response tracker per master.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_MST; i++) begin
      if (reset) begin
        resp_r[i] <= '0;
      end else begin
        resp_r[i].valid   <= m_gnt[i];
        resp_r[i].slv_idx <= sel_idx_s[i];
        resp_r[i].miss    <= miss_s[i];
      end
    end
  end

  // Response routing; a pending response is suppressed while reset is high.
  always_comb begin
    m_rvalid = '0;
    m_rdata  = '0;
    m_err    = '0;
    for (int i = 0; i < N_MST; i++) begin
      m_rvalid[i] = resp_r[i].valid && !reset;
      m_err[i]    = m_rvalid[i] && resp_r[i].miss;
      for (int j = 0; j < N_SLV; j++) begin
        if (m_rvalid[i] && !resp_r[i].miss && (resp_r[i].slv_idx == MAX_IDX_W'(j))) begin
          m_rdata[i*DW +: DW] = s_rdata[j*DW +: DW];
          m_err[i]            = s_err[j];
        end else begin
          m_rdata[i*DW +: DW] = m_rdata[i*DW +: DW];
        end
      end
    end
  end

`ifdef ZERORISCY_MXBAR_STATS_EN
  logic [31:0] stall_r [N_MST];

  // Saturating stall counters; clear wins over increment.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_MST; i++) begin
      if (reset || stat_clr) begin
        stall_r[i] <= 32'd0;
      end else if (m_req[i] && !m_gnt[i] && (stall_r[i] != 32'hFFFF_FFFF)) begin
        stall_r[i] <= stall_r[i] + 32'd1;
      end else begin
        stall_r[i] <= stall_r[i];
      end
    end
  end

  // Flatten counters onto the stat port.
  always_comb begin
    stat_stall = '0;
    for (int i = 0; i < N_MST; i++) begin
      stat_stall[i*32 +: 32] = stall_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_zeroriscy_mxbar.sv
// Directed bench for zeroriscy_mxbar (2 masters, 3 slaves, default address map).
// Slave model answers reads one cycle later with {slave_no+1, addr[23:0]}.
module tb_zeroriscy_mxbar;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   m_req, m_we, m_gnt, m_rvalid, m_err;
  logic [7:0]   m_be;
  logic [63:0]  m_addr, m_wdata, m_rdata;
  logic [2:0]   s_req, s_we, s_err;
  logic [11:0]  s_be;
  logic [95:0]  s_addr, s_wdata, s_rdata;
`ifdef ZERORISCY_MXBAR_STATS_EN
  logic         stat_clr;
  logic [63:0]  stat_stall;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  zeroriscy_mxbar dut (
    .clk        (clk),
    .reset      (reset),
`ifdef ZERORISCY_MXBAR_STATS_EN
    .stat_clr   (stat_clr),
    .stat_stall (stat_stall),
`endif
    .m_req      (m_req),
    .m_we       (m_we),
    .m_be       (m_be),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_gnt      (m_gnt),
    .m_rvalid   (m_rvalid),
    .m_rdata    (m_rdata),
    .m_err      (m_err),
    .s_req      (s_req),
    .s_we       (s_we),
    .s_be       (s_be),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .s_rdata    (s_rdata),
    .s_err      (s_err)
  );

  always #5 clk = ~clk;

  // Fixed-latency SRAM-style slaves; low address bits 12'hBAD flag an error.
  always @(posedge clk) begin
    for (int j = 0; j < 3; j++) begin
      s_rdata[j*32 +: 32] <= s_req[j] ? {8'(j + 1), s_addr[j*32 +: 24]} : 32'h0;
      s_err[j]            <= s_req[j] && (s_addr[j*32 +: 12] == 12'hBAD);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_m(input int i, input logic req, input logic we,
                       input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    m_req[i]          = req;
    m_we[i]           = we;
    m_addr[i*32 +: 32]  = addr;
    m_be[i*4 +: 4]      = be;
    m_wdata[i*32 +: 32] = wd;
  endtask

  task automatic idle();
    m_req = 2'b00; m_we = 2'b00; m_be = 8'h00; m_addr = 64'h0; m_wdata = 64'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    idle();
    s_rdata = 96'h0;
    s_err   = 3'b000;
`ifdef ZERORISCY_MXBAR_STATS_EN
    stat_clr = 1'b0;
`endif
    // Reset with requests held high: nothing may be granted.
    reset = 1'b1;
    set_m(0, 1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0);
    @(negedge clk); @(negedge clk);
    #1;
    check("rst_gnt",    64'(m_gnt),    64'h0);
    check("rst_sreq",   64'(s_req),    64'h0);
    check("rst_rvalid", 64'(m_rvalid), 64'h0);
    check("rst_rdata",  m_rdata,       64'h0);
    check("rst_err",    64'(m_err),    64'h0);
    idle();
    @(negedge clk);
    reset = 1'b0;

    // 1: parallel grants to different slaves.
    set_m(0, 1'b1, 1'b0, 32'h8000_0010, 4'hF, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h8010_0020, 4'hF, 32'h0);
    #1;
    check("t1_gnt",   64'(m_gnt),      64'h3);
    check("t1_sreq",  64'(s_req),      64'h3);
    check("t1_addr0", 64'(s_addr[31:0]),  64'h8000_0010);
    check("t1_addr1", 64'(s_addr[63:32]), 64'h8010_0020);
    @(negedge clk);
    idle();
    #1;
    check("t1_rvalid", 64'(m_rvalid), 64'h3);
    check("t1_rdata0", 64'(m_rdata[31:0]),  64'h0100_0010);
    check("t1_rdata1", 64'(m_rdata[63:32]), 64'h0210_0020);
    check("t1_err",    64'(m_err), 64'h0);
    @(negedge clk);
    #1;
    check("t1_idle_rvalid", 64'(m_rvalid), 64'h0);
    check("t1_idle_rdata",  m_rdata,       64'h0);

    // 2: contention on slave 0 from reset alternates M0, M1, M0, M1.
    do_reset();
    set_m(0, 1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t2_gnt%0d", k), 64'(m_gnt), (k % 2 == 0) ? 64'h1 : 64'h2);
      if (k > 0) begin
        check($sformatf("t2_rv%0d", k), 64'(m_rvalid), (k % 2 == 0) ? 64'h2 : 64'h1);
      end else begin
        check("t2_rv0", 64'(m_rvalid), 64'h0);
      end
      @(negedge clk);
    end
    idle();
    @(negedge clk);

    // 3: decode miss.
    set_m(1, 1'b1, 1'b0, 32'h0000_1000, 4'hF, 32'h0);
    #1;
    check("t3_gnt",  64'(m_gnt), 64'h2);
    check("t3_sreq", 64'(s_req), 64'h0);
    @(negedge clk);
    idle();
    #1;
    check("t3_rvalid", 64'(m_rvalid), 64'h2);
    check("t3_err",    64'(m_err),    64'h2);
    check("t3_rdata",  m_rdata,       64'h0);

    // 4: back-to-back reads from M0 to slave 2.
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      set_m(0, 1'b1, 1'b0, 32'h4000_0000 + 32'(4 * k), 4'hF, 32'h0);
      #1;
      check($sformatf("t4_gnt%0d", k), 64'(m_gnt), 64'h1);
      if (k > 0) begin
        check($sformatf("t4_rv%0d", k),   64'(m_rvalid), 64'h1);
        check($sformatf("t4_data%0d", k), 64'(m_rdata[31:0]), 64'h0300_0000 + 64'(4 * (k - 1)));
      end else begin
        check("t4_rv0", 64'(m_rvalid), 64'h0);
      end
      @(negedge clk);
    end
    idle();
    #1;
    check("t4_rv3",   64'(m_rvalid), 64'h1);
    check("t4_data3", 64'(m_rdata[31:0]), 64'h0300_0008);

    // Slave error and write path.
    @(negedge clk);
    set_m(0, 1'b1, 1'b0, 32'h8000_0BAD, 4'hF, 32'h0);
    set_m(1, 1'b1, 1'b1, 32'h4000_0010, 4'hC, 32'hDEAD_BEEF);
    #1;
    check("wr_swe",   64'(s_we),   64'h4);
    check("wr_sbe",   64'(s_be[11:8]), 64'hC);
    check("wr_swd",   64'(s_wdata[95:64]), 64'hDEAD_BEEF);
    check("wr_saddr", 64'(s_addr[95:64]),  64'h4000_0010);
    @(negedge clk);
    idle();
    #1;
    check("err_rvalid", 64'(m_rvalid), 64'h3);
    check("err_err",    64'(m_err),    64'h1);

    // 5: reset right after a grant discards the response and clears rr_ptr.
    @(negedge clk);
    set_m(0, 1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0);
    #1;
    check("t5_gnt", 64'(m_gnt), 64'h1);
    @(negedge clk);
    idle();
    reset = 1'b1;
    #1;
    check("t5_rv_rst", 64'(m_rvalid), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t5_rv_after", 64'(m_rvalid), 64'h0);
    set_m(0, 1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0);
    #1;
    check("t5_ptr0", 64'(m_gnt), 64'h1);
    @(negedge clk);
    idle();
    @(negedge clk);

`ifdef ZERORISCY_MXBAR_STATS_EN
    // 6: stall counters and clear.
    do_reset();
    set_m(0, 1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0);
    set_m(1, 1'b1, 1'b0, 32'h8000_0000, 4'hF, 32'h0);
    repeat (5) @(negedge clk);
    #1;
    check("t6_stall1", 64'(stat_stall[63:32]), 64'd3);
    check("t6_stall0", 64'(stat_stall[31:0]),  64'd2);
    stat_clr = 1'b1;
    @(negedge clk);
    stat_clr = 1'b0;
    idle();
    #1;
    check("t6_clr1", 64'(stat_stall[63:32]), 64'd0);
    check("t6_clr0", 64'(stat_stall[31:0]),  64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
